// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: stage strobe bit positions,
// data-bus FSM state encodings and strobe level constants.
package pipe_ctrl_pkg;

   localparam int NUM_STG    = 5;
   localparam int STG_PC     = 0;
   localparam int STG_IF_ID  = 1;
   localparam int STG_ID_EX  = 2;
   localparam int STG_EX_MEM = 3;
   localparam int STG_WB     = 4;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_REQ       = 2'd1;
   localparam logic [1:0] ST_WAIT_RESP = 2'd2;

   // Builds a strobe vector from per-stage flags, in pc..mem_wb order.
   function automatic logic [NUM_STG-1:0] stg_mask(
      input logic pc,
      input logic if_id,
      input logic id_ex,
      input logic ex_mem,
      input logic wb
   );
      logic [NUM_STG-1:0] m;
      m             = '0;
      m[STG_PC]     = pc;
      m[STG_IF_ID]  = if_id;
      m[STG_ID_EX]  = id_ex;
      m[STG_EX_MEM] = ex_mem;
      m[STG_WB]     = wb;
      return m;
   endfunction

endpackage

// File: rtl/pipe_ctrl_dbus_fsm.sv
// Data-bus handshake FSM for loads/stores in MEM: issues the request, waits for
// grant and response, and declares a timeout when the bus never completes.
module dbus_fsm
   import pipe_ctrl_pkg::*;
#(
   parameter int BUS_TIMEOUT = 255,
   parameter int CNT_W       = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic mem_req,
   input  logic trap_req,
   input  logic dbus_gnt,
   input  logic dbus_rvalid,
   output logic dbus_req,
   output logic mem_wait,
   output logic timeout,
   output logic idle
);

   logic [1:0]       state;
   logic [1:0]       state_next;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic             issue;
   logic             busy;
   logic             done;

   // A pending trap suppresses a new request; the trap wins in IDLE.
   assign idle     = (state == ST_IDLE);
   assign issue    = idle && mem_req && !trap_req;
   assign busy     = (state == ST_REQ) || (state == ST_WAIT_RESP);
   assign done     = (state == ST_WAIT_RESP) && dbus_rvalid;
   assign timeout  = busy && (count == CNT_W'(BUS_TIMEOUT)) && !done;
   assign dbus_req = issue || (state == ST_REQ);
   assign mem_wait = issue || (state == ST_REQ) ||
                     ((state == ST_WAIT_RESP) && !dbus_rvalid);

   // The counter holds the number of cycles since the request was issued,
   // so the issue cycle itself counts toward the timeout.
   always_comb begin
      state_next = state;
      count_next = '0;
      case (state)
         ST_IDLE: begin
            if (issue) begin
               state_next = dbus_gnt ? ST_WAIT_RESP : ST_REQ;
               count_next = CNT_W'(1);
            end
         end
         ST_REQ: begin
            if (timeout) begin
               state_next = ST_IDLE;
            end else begin
               if (dbus_gnt) begin
                  state_next = ST_WAIT_RESP;
               end
               count_next = count + 1'b1;
            end
         end
         ST_WAIT_RESP: begin
            if (timeout || done) begin
               state_next = ST_IDLE;
            end else begin
               count_next = count + 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         count <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: per-stage stall/flush strobes, PC redirect on
// branch or trap, and the data-bus handshake for MEM-stage loads and stores.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int BUS_TIMEOUT = 255,
   parameter int CNT_W       = 8,
   parameter int ADDR_W      = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stallreq_id_i,
   input  logic               stallreq_ex_i,
   input  logic               branch_flag_i,
   input  logic [ADDR_W-1:0]  branch_target_i,
   input  logic               trap_req_i,
   input  logic [ADDR_W-1:0]  trap_vector_i,
   input  logic               mem_req_i,
   input  logic               dbus_gnt_i,
   input  logic               dbus_rvalid_i,
   output logic               dbus_req_o,
   output logic [NUM_STG-1:0] stall_o,
   output logic [NUM_STG-1:0] flush_o,
   output logic               new_pc_flag_o,
   output logic [ADDR_W-1:0]  new_pc_o,
   output logic               bus_err_o
);

   logic mem_wait;
   logic timeout;
   logic idle;
   logic take_trap;

   dbus_fsm #(
      .BUS_TIMEOUT (BUS_TIMEOUT),
      .CNT_W       (CNT_W)
   ) u_dbus_fsm (
      .clk         (clk),
      .rst_n       (rst_n),
      .mem_req     (mem_req_i),
      .trap_req    (trap_req_i),
      .dbus_gnt    (dbus_gnt_i),
      .dbus_rvalid (dbus_rvalid_i),
      .dbus_req    (dbus_req_o),
      .mem_wait    (mem_wait),
      .timeout     (timeout),
      .idle        (idle)
   );

   // Traps are only taken in IDLE since a granted transaction cannot be aborted.
   assign take_trap = (idle && trap_req_i) || timeout;
   assign bus_err_o = timeout;

   // Priority: trap, memory wait, divider busy, branch, load-use. A branch
   // under a stall is simply not acted on until the stall drops.
   always_comb begin
      stall_o       = '0;
      flush_o       = '0;
      new_pc_flag_o = NO_STOP;
      new_pc_o      = '0;
      if (take_trap) begin
         flush_o       = stg_mask(NO_STOP, STOP, STOP, STOP, timeout);
         new_pc_flag_o = STOP;
         new_pc_o      = trap_vector_i;
      end else if (mem_wait) begin
         stall_o = stg_mask(STOP, STOP, STOP, STOP, NO_STOP);
         flush_o = stg_mask(NO_STOP, NO_STOP, NO_STOP, NO_STOP, STOP);
      end else if (stallreq_ex_i) begin
         stall_o = stg_mask(STOP, STOP, STOP, NO_STOP, NO_STOP);
         flush_o = stg_mask(NO_STOP, NO_STOP, NO_STOP, STOP, NO_STOP);
      end else if (branch_flag_i) begin
         flush_o       = stg_mask(NO_STOP, STOP, STOP, NO_STOP, NO_STOP);
         new_pc_flag_o = STOP;
         new_pc_o      = branch_target_i;
      end else if (stallreq_id_i) begin
         stall_o = stg_mask(STOP, STOP, NO_STOP, NO_STOP, NO_STOP);
         flush_o = stg_mask(NO_STOP, NO_STOP, STOP, NO_STOP, NO_STOP);
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a transaction-level model predicts every
// cycle's outputs, and a monitor compares them against the DUT at negedge.
module tb_pipe_ctrl;

   localparam int TO = 255;
   localparam int CW = 8;
   localparam int AW = 32;

   logic          clk;
   logic          rst_n;
   logic          stallreq_id;
   logic          stallreq_ex;
   logic          branch_flag;
   logic [AW-1:0] branch_target;
   logic          trap_req;
   logic [AW-1:0] trap_vector;
   logic          mem_req;
   logic          dbus_gnt;
   logic          dbus_rvalid;
   logic          dbus_req;
   logic [4:0]    stall;
   logic [4:0]    flush;
   logic          new_pc_flag;
   logic [AW-1:0] new_pc;
   logic          bus_err;

   pipe_ctrl #(
      .BUS_TIMEOUT (TO),
      .CNT_W       (CW),
      .ADDR_W      (AW)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .stallreq_id_i   (stallreq_id),
      .stallreq_ex_i   (stallreq_ex),
      .branch_flag_i   (branch_flag),
      .branch_target_i (branch_target),
      .trap_req_i      (trap_req),
      .trap_vector_i   (trap_vector),
      .mem_req_i       (mem_req),
      .dbus_gnt_i      (dbus_gnt),
      .dbus_rvalid_i   (dbus_rvalid),
      .dbus_req_o      (dbus_req),
      .stall_o         (stall),
      .flush_o         (flush),
      .new_pc_flag_o   (new_pc_flag),
      .new_pc_o        (new_pc),
      .bus_err_o       (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic          req;
      logic [4:0]    stall;
      logic [4:0]    flush;
      logic          flag;
      logic [AW-1:0] pc;
      logic          err;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passes = 0;
   int   cycle_no = 0;

   // Model of the outstanding bus transaction: in flight, granted, age in cycles.
   bit   m_busy = 0;
   bit   m_granted = 0;
   int   m_age = 0;

   task automatic applyStimulus(
      input logic          rst,
      input logic          mreq,
      input logic          trap,
      input logic          gnt,
      input logic          rvalid,
      input logic          sid,
      input logic          sex,
      input logic          br,
      input logic [AW-1:0] tgt,
      input logic [AW-1:0] vec
   );
      exp_t e;
      bit   issue;
      bit   done;
      bit   tmo;
      bit   trap_now;
      bit   waitq;
      @(posedge clk);
      #1;
      rst_n         = rst;
      mem_req       = mreq;
      trap_req      = trap;
      dbus_gnt      = gnt;
      dbus_rvalid   = rvalid;
      stallreq_id   = sid;
      stallreq_ex   = sex;
      branch_flag   = br;
      branch_target = tgt;
      trap_vector   = vec;
      if (!rst) m_busy = 0;
      e     = '0;
      issue = 0;
      done  = 0;
      tmo   = 0;
      if (!m_busy) begin
         issue    = mreq && !trap;
         trap_now = trap;
         e.req    = issue;
         waitq    = issue;
      end else begin
         done     = m_granted && rvalid;
         tmo      = (m_age == TO) && !done;
         trap_now = tmo;
         e.req    = !m_granted;
         waitq    = !done;
      end
      e.err = tmo;
      if (trap_now) begin
         e.flush = tmo ? 5'b11110 : 5'b01110;
         e.flag  = 1'b1;
         e.pc    = vec;
      end else if (waitq) begin
         e.stall = 5'b01111;
         e.flush = 5'b10000;
      end else if (sex) begin
         e.stall = 5'b00111;
         e.flush = 5'b01000;
      end else if (br) begin
         e.flush = 5'b00110;
         e.flag  = 1'b1;
         e.pc    = tgt;
      end else if (sid) begin
         e.stall = 5'b00011;
         e.flush = 5'b00100;
      end
      sb.push_back(e);
      if (rst) begin
         if (!m_busy) begin
            if (issue) begin
               m_busy    = 1;
               m_granted = gnt;
               m_age     = 1;
            end
         end else if (tmo || done) begin
            m_busy = 0;
         end else begin
            m_granted = m_granted || gnt;
            m_age     = m_age + 1;
         end
      end
   endtask

   task automatic checkOutput(input exp_t e);
      exp_t got;
      got = '{req: dbus_req, stall: stall, flush: flush, flag: new_pc_flag,
              pc: new_pc, err: bus_err};
      checks++;
      if (got === e) begin
         passes++;
      end else begin
         $display("[TB] FAIL cycle %0d: got req=%b stall=%b flush=%b flag=%b pc=%h err=%b, expected req=%b stall=%b flush=%b flag=%b pc=%h err=%b",
                  cycle_no, got.req, got.stall, got.flush, got.flag, got.pc, got.err,
                  e.req, e.stall, e.flush, e.flag, e.pc, e.err);
      end
   endtask

   // Monitor: the DUT presents a full output set every cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cycle_no++;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput(e);
         end
      end
   end

   task automatic idleCycle(input logic rst);
      applyStimulus(rst, 0, 0, 0, 0, 0, 0, 0, '0, '0);
   endtask

   initial begin
      logic [AW-1:0] vec;
      logic [AW-1:0] tgt;
      bit            stuck;
      rst_n = 0; mem_req = 0; trap_req = 0; dbus_gnt = 0; dbus_rvalid = 0;
      stallreq_id = 0; stallreq_ex = 0; branch_flag = 0;
      branch_target = '0; trap_vector = '0;

      idleCycle(0);
      idleCycle(0);
      idleCycle(1);

      // Granted load, response two cycles later.
      applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, '0, '0);
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, '0, '0);
      applyStimulus(1, 1, 0, 0, 1, 0, 0, 0, '0, '0);
      idleCycle(1);

      // Never granted: bus error on the 256th cycle.
      vec = 32'h8000_0100;
      for (int i = 0; i < 256; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, '0, vec);
      idleCycle(1);

      // Granted but never answered.
      applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, '0, vec);
      for (int i = 0; i < 255; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, '0, vec);
      idleCycle(1);

      // Divider busy holds a branch; branch beats load-use.
      tgt = 32'h0000_4000;
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, tgt, '0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, tgt, '0);
      applyStimulus(1, 0, 0, 0, 0, 1, 0, 1, tgt, '0);
      applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, tgt, '0);

      // Trap ignored during WAIT_RESP, taken in the following IDLE cycle.
      vec = 32'h0000_0040;
      applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, '0, vec);
      applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, '0, vec);
      applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, '0, vec);
      applyStimulus(1, 1, 1, 0, 1, 0, 0, 0, '0, vec);
      applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, '0, vec);
      idleCycle(1);

      // Reset in the middle of REQ.
      for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, '0, vec);
      idleCycle(0);
      idleCycle(1);
      applyStimulus(1, 0, 0, 1, 1, 0, 0, 0, '0, vec);

      // Randomized traffic, with stretches where the bus goes silent.
      stuck = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(499) == 0) stuck = ~stuck;
         applyStimulus($urandom_range(199) != 0,
                       $urandom_range(99) < 45,
                       $urandom_range(99) < 10,
                       !stuck && ($urandom_range(99) < 50),
                       !stuck && ($urandom_range(99) < 40),
                       $urandom_range(99) < 25,
                       $urandom_range(99) < 20,
                       $urandom_range(99) < 25,
                       $urandom, $urandom);
      end

      idleCycle(1);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (sb.size() == 0) passes++;
      else $display("[TB] FAIL scoreboard drain: %0d left, expected 0", sb.size());
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. It generates the per-register stall and flush strobes for pc, if_id, id_ex, ex_mem and mem_wb, and owns the data-bus handshake FSM for loads and stores in MEM. It also redirects the PC on branches and traps, and raises a bus-error trap on handshake timeout.

Parameters:
BUS_TIMEOUT, 255, cycles in REQ/WAIT_RESP before bus error is declared (1..2^CNT_W-1)
CNT_W, 8, timeout counter width
ADDR_W, 32, PC / vector width

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous reset, active low
stallreq_id_i  in  1  load-use hazard detected in ID
stallreq_ex_i  in  1  multi-cycle EX op (divider) busy
branch_flag_i  in  1  taken branch/jump resolved in EX
branch_target_i  in  ADDR_W  branch destination
trap_req_i  in  1  exception/interrupt request from MEM
trap_vector_i  in  ADDR_W  trap handler address (mtvec)
mem_req_i  in  1  instruction in MEM is a load or store
dbus_gnt_i  in  1  data bus accepted request
dbus_rvalid_i  in  1  data bus response (read data or write ack)
dbus_req_o  out  1  data bus request
stall_o  out  5  hold strobes: [0]=pc [1]=if_id [2]=id_ex [3]=ex_mem [4]=mem_wb
flush_o  out  5  bubble strobes, same bit mapping
new_pc_flag_o  out  1  redirect PC this cycle
new_pc_o  out  ADDR_W  redirect target
bus_err_o  out  1  one-cycle pulse on timeout

Behaviour:
- Interface: one clock, clk; reset rst_n asynchronous, active-low.
- FSM states: IDLE, REQ (request issued, no grant), WAIT_RESP (granted, awaiting rvalid). Registered: state, timeout counter.
- dbus_req_o is combinational: 1 in IDLE when mem_req_i=1 and trap_req_i=0, and 1 throughout REQ.
- IDLE -> WAIT_RESP when the request is issued and dbus_gnt_i=1 in the same cycle. IDLE -> REQ when it is issued without a grant.
- REQ -> WAIT_RESP on dbus_gnt_i. WAIT_RESP -> IDLE on dbus_rvalid_i.
- Counter: cleared in IDLE, increments each cycle in REQ/WAIT_RESP. If it reaches BUS_TIMEOUT without completion, assert bus_err_o, force a trap and go to IDLE.
- mem_wait = (IDLE and request issued) or REQ or (WAIT_RESP and not dbus_rvalid_i). The rvalid cycle is not stalled, so minimum load/store occupancy is 2 cycles.
- stall_o, flush_o, new_pc_flag_o and new_pc_o are combinational. Priority is highest first:
  1. trap (trap_req_i in IDLE, or timeout): flush_o=5'b01110 (if_id, id_ex, ex_mem) plus bit4 on timeout only; stall_o=0; new_pc=trap_vector_i.
  2. mem_wait: stall_o=5'b01111, flush_o=5'b10000.
  3. stallreq_ex_i: stall_o=5'b00111, flush_o=5'b01000.
  4. branch_flag_i: flush_o=5'b00110, new_pc=branch_target_i.
  5. stallreq_id_i: stall_o=5'b00011, flush_o=5'b00100.
  6. Otherwise all outputs are 0.
- trap_req_i is ignored outside IDLE, because granted transactions cannot be aborted. The source holds the request until it is taken.
- A branch coincident with mem_wait or div busy is held, since id_ex/ex_mem are stalled. It takes effect when the stall drops.
- Branch beats load-use: the ID instruction is on the wrong path.
- Reset values: state=IDLE, counter=0. With idle inputs, every output is 0 (dbus_req_o=0, stall_o=0, flush_o=0, new_pc_flag_o=0, new_pc_o=0, bus_err_o=0). Reset mid-transaction abandons it without an error pulse.

Decomposition:
- Shared defs header: stage-bit index constants (STG_PC..STG_WB), FSM state encodings, `Stop/`NoStop, `ZeroWord.
- One sub-module: dbus_fsm (state, counter, dbus_req_o, mem_wait, timeout). The priority encoder stays in pipe_ctrl.

Test Plan:
1. Reset, all inputs 0 -> every output 0 and state IDLE.
2. mem_req_i=1, dbus_gnt_i=1 at cycle 0, rvalid at cycle 2 -> stall_o=5'b01111 and flush_o=5'b10000 on cycles 0-1; cycle 2 stall_o=0; state returns to IDLE.
3. mem_req_i=1, no gnt for 255 cycles -> on cycle 255 bus_err_o=1 for 1 cycle, new_pc_o=trap_vector_i, flush_o=5'b11110, dbus_req_o drops.
4. stallreq_ex_i and branch_flag_i together -> stall_o=5'b00111, flush_o=5'b01000. After busy drops, flush_o=5'b00110, new_pc_o=branch_target_i.
5. branch_flag_i and stallreq_id_i together -> flush_o=5'b00110, stall_o=0.
6. trap_req_i during WAIT_RESP -> ignored until rvalid. Next IDLE cycle flush_o=5'b01110 and new_pc_o=trap_vector_i. rst_n pulsed mid-REQ -> immediate IDLE and dbus_req_o=0.
